// File: rtl/id_stage_param.sv
// MUSA decode stage: register file with write-back bypass, immediate extension,
// destination select and a handshaked ID/EX pipeline register with load-use stall.
module id_stage_param #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int IMM_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic              ctrl_reg_dst,
    input  logic              ctrl_zext,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_reg_write,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [25:0]       ex_jump,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [25:0]       jump;
    } id_ex_t;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    id_ex_t            ex_q;
    id_ex_t            ex_d;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic              wb_write;
    logic              hazard;
    logic              can_load;

    // The opcode is decoded by the control unit, not here.
    logic unused_opcode;
    assign unused_opcode = ^if_instr[31:26];

    assign rs = if_instr[25:21];
    assign rt = if_instr[20:16];
    assign rd = if_instr[15:11];

    assign wb_write = wb_en && (wb_addr != 5'd0) && (int'(wb_addr) < NUM_REGS);

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        rf_d = rf_q;
        rf_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_write && (wb_addr == 5'(i))) begin
                rf_d[i] = wb_data;
            end
        end
    end

    // Read ports: unimplemented indices read zero; a same-cycle write wins.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == 5'(i)) rs_val = rf_q[i];
            if (rt == 5'(i)) rt_val = rf_q[i];
        end
        if (wb_write && (wb_addr == rs)) rs_val = wb_data;
        if (wb_write && (wb_addr == rt)) rt_val = wb_data;
    end

    always_comb begin
        imm_ext = '0;
        if (ctrl_zext) begin
            imm_ext = DATA_W'(if_instr[IMM_W-1:0]);
        end else begin
            imm_ext = DATA_W'($signed(if_instr[IMM_W-1:0]));
        end
    end

    // rt is compared even for instructions that do not read it, which is safe but conservative.
    assign hazard   = ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
                      ((ex_q.dest == rs) || (ex_q.dest == rt));
    assign can_load = !ex_q.valid || ex_ready;
    assign if_ready = can_load && !hazard && !flush && !rst;

    always_comb begin
        ex_d    = ex_q;
        stall_d = stall_q;
        if (flush) begin
            ex_d.valid     = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.reg_write = 1'b0;
        end else if (can_load && hazard) begin
            ex_d.valid     = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.reg_write = 1'b0;
            if (stall_q != '1) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end else if (can_load) begin
            ex_d.valid     = if_valid;
            ex_d.mem_read  = ctrl_mem_read;
            ex_d.reg_write = ctrl_reg_write;
            ex_d.rs_data   = rs_val;
            ex_d.rt_data   = rt_val;
            ex_d.imm       = imm_ext;
            ex_d.rs        = rs;
            ex_d.rt        = rt;
            ex_d.dest      = ctrl_reg_dst ? rd : rt;
            ex_d.jump      = if_instr[25:0];
        end
    end

    // NOTE: the register file is reset because software relies on registers reading zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            ex_q    <= '0;
            stall_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            rf_q    <= rf_d;
            ex_q    <= ex_d;
            stall_q <= stall_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_dest      = ex_q.dest;
    assign ex_jump      = ex_q.jump;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: default instance plus a narrow
// instance (DATA_W=16, NUM_REGS=8, CNT_W=2) for range and saturation cases.
module tb_id_stage_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Default instance
    logic        if_valid, if_ready, ctrl_reg_dst, ctrl_zext, ctrl_mem_read, ctrl_reg_write;
    logic        flush, wb_en, ex_valid, ex_ready, ex_mem_read, ex_reg_write;
    logic [31:0] if_instr, wb_data, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  wb_addr, ex_rs, ex_rt, ex_dest;
    logic [25:0] ex_jump;
    logic [15:0] stall_count;

    // Narrow instance
    logic        s_if_valid, s_if_ready, s_ctrl_reg_dst, s_ctrl_zext, s_ctrl_mem_read, s_ctrl_reg_write;
    logic        s_flush, s_wb_en, s_ex_valid, s_ex_ready, s_ex_mem_read, s_ex_reg_write;
    logic [31:0] s_if_instr;
    logic [15:0] s_wb_data, s_ex_rs_data, s_ex_rt_data, s_ex_imm;
    logic [4:0]  s_wb_addr, s_ex_rs, s_ex_rt, s_ex_dest;
    logic [25:0] s_ex_jump;
    logic [1:0]  s_stall_count;

    id_stage_param u_dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .ctrl_reg_dst(ctrl_reg_dst), .ctrl_zext(ctrl_zext),
        .ctrl_mem_read(ctrl_mem_read), .ctrl_reg_write(ctrl_reg_write),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_jump(ex_jump), .stall_count(stall_count)
    );

    id_stage_param #(.DATA_W(16), .NUM_REGS(8), .IMM_W(16), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst),
        .if_valid(s_if_valid), .if_ready(s_if_ready), .if_instr(s_if_instr),
        .ctrl_reg_dst(s_ctrl_reg_dst), .ctrl_zext(s_ctrl_zext),
        .ctrl_mem_read(s_ctrl_mem_read), .ctrl_reg_write(s_ctrl_reg_write),
        .flush(s_flush), .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
        .ex_valid(s_ex_valid), .ex_ready(s_ex_ready),
        .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm),
        .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_dest(s_ex_dest),
        .ex_mem_read(s_ex_mem_read), .ex_reg_write(s_ex_reg_write),
        .ex_jump(s_ex_jump), .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h23, rs, rt, imm};
    endfunction

    initial begin
        rst = 1'b1;
        if_valid = 0; if_instr = '0; ctrl_reg_dst = 0; ctrl_zext = 0; ctrl_mem_read = 0;
        ctrl_reg_write = 0; flush = 0; wb_en = 0; wb_addr = '0; wb_data = '0; ex_ready = 1;
        s_if_valid = 0; s_if_instr = '0; s_ctrl_reg_dst = 0; s_ctrl_zext = 0; s_ctrl_mem_read = 0;
        s_ctrl_reg_write = 0; s_flush = 0; s_wb_en = 0; s_wb_addr = '0; s_wb_data = '0; s_ex_ready = 1;

        // Reset state
        #3;
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_if_ready", 32'(if_ready), 32'd1);

        // Write r5, attempt r0, then read both
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        tick();
        wb_en = 0;
        if_valid = 1; if_instr = mk(5'd5, 5'd0, 16'h0000);
        tick();
        check("rd_r5_valid", 32'(ex_valid), 32'd1);
        check("rd_r5_data", ex_rs_data, 32'hDEADBEEF);
        check("rd_r0_data", ex_rt_data, 32'h0);
        check("rd_r5_idx", 32'(ex_rs), 32'd5);
        if_valid = 0;
        tick();
        check("idle_ex_valid", 32'(ex_valid), 32'd0);

        // Same-cycle write-back bypass on rt
        if_valid = 1; if_instr = mk(5'd5, 5'd7, 16'h0000);
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h12345678;
        tick();
        wb_en = 0;
        check("bypass_rt_data", ex_rt_data, 32'h12345678);
        check("bypass_rt_idx", 32'(ex_rt), 32'd7);

        // Immediate extension and destination select
        if_instr = mk(5'd1, 5'd2, 16'h8001); ctrl_zext = 0; ctrl_reg_dst = 0;
        tick();
        check("sext_imm", ex_imm, 32'hFFFF8001);
        check("dest_rt", 32'(ex_dest), 32'd2);
        check("jump_field", 32'(ex_jump), 32'h0228001);
        ctrl_zext = 1; ctrl_reg_dst = 1;
        tick();
        check("zext_imm", ex_imm, 32'h00008001);
        check("dest_rd", 32'(ex_dest), 32'd16);
        ctrl_zext = 0; ctrl_reg_dst = 0;

        // Load-use: load r3 then consumer of r3
        if_instr = mk(5'd0, 5'd3, 16'h0000); ctrl_mem_read = 1; ctrl_reg_write = 1;
        tick();
        check("load_mem_read", 32'(ex_mem_read), 32'd1);
        check("load_dest", 32'(ex_dest), 32'd3);
        if_instr = mk(5'd3, 5'd0, 16'h0000); ctrl_mem_read = 0;
        #1;
        check("hazard_if_ready", 32'(if_ready), 32'd0);
        tick();
        check("bubble_ex_valid", 32'(ex_valid), 32'd0);
        check("bubble_mem_read", 32'(ex_mem_read), 32'd0);
        check("bubble_stall", 32'(stall_count), 32'd1);
        check("after_bubble_if_ready", 32'(if_ready), 32'd1);
        tick();
        check("dep_accepted", 32'(ex_valid), 32'd1);
        check("dep_rs", 32'(ex_rs), 32'd3);

        // Load to r0 never stalls
        if_instr = mk(5'd0, 5'd0, 16'h0000); ctrl_mem_read = 1;
        tick();
        check("load0_mem_read", 32'(ex_mem_read), 32'd1);
        if_instr = mk(5'd0, 5'd0, 16'h1234); ctrl_mem_read = 0;
        #1;
        check("load0_if_ready", 32'(if_ready), 32'd1);
        tick();
        check("load0_next_imm", ex_imm, 32'h00001234);
        check("load0_stall", 32'(stall_count), 32'd1);

        // Back-pressure with a pending hazard, then flush during the hold
        if_instr = mk(5'd0, 5'd4, 16'h1234); ctrl_mem_read = 1;
        tick();
        check("bp_load_dest", 32'(ex_dest), 32'd4);
        ex_ready = 0;
        if_instr = mk(5'd4, 5'd0, 16'h5555); ctrl_mem_read = 0;
        #1;
        check("bp_if_ready", 32'(if_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", 32'(ex_valid), 32'd1);
            check("bp_hold_imm", ex_imm, 32'h00001234);
            check("bp_hold_mem_read", 32'(ex_mem_read), 32'd1);
            check("bp_hold_stall", 32'(stall_count), 32'd1);
        end
        flush = 1;
        tick();
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_mem_read", 32'(ex_mem_read), 32'd0);
        check("flush_reg_write", 32'(ex_reg_write), 32'd0);
        flush = 0; ex_ready = 1;
        #1;
        check("post_flush_if_ready", 32'(if_ready), 32'd1);
        tick();
        check("post_flush_imm", ex_imm, 32'h00005555);
        check("post_flush_stall", 32'(stall_count), 32'd1);

        // The bypassed write to r7 was also committed
        if_instr = mk(5'd7, 5'd0, 16'h0000); ctrl_reg_write = 0;
        tick();
        check("r7_committed", ex_rs_data, 32'h12345678);
        if_valid = 0;

        // Narrow instance: out-of-range write ignored, 16-bit immediate
        s_wb_en = 1; s_wb_addr = 5'd9; s_wb_data = 16'hBEEF;
        tick();
        s_wb_addr = 5'd7; s_wb_data = 16'h1111;
        tick();
        s_wb_en = 0;
        s_if_valid = 1; s_if_instr = mk(5'd9, 5'd7, 16'h8000);
        tick();
        check("s_r9_reads_0", 32'(s_ex_rs_data), 32'h0);
        check("s_r7_data", 32'(s_ex_rt_data), 32'h1111);
        check("s_imm_16", 32'(s_ex_imm), 32'h8000);
        s_if_instr = mk(5'd1, 5'd9, 16'h0000);
        tick();
        check("s_r1_untouched", 32'(s_ex_rs_data), 32'h0);
        check("s_r9_rt_0", 32'(s_ex_rt_data), 32'h0);

        // Narrow instance: repeated self-dependent loads saturate a 2-bit counter
        s_if_instr = mk(5'd3, 5'd3, 16'h0000); s_ctrl_mem_read = 1; s_ctrl_reg_write = 1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k % 2 == 0) begin
                check("s_stall_sat", 32'(s_stall_count), (k / 2 > 3) ? 32'd3 : 32'(k / 2));
            end
        end
        s_if_valid = 0; s_ctrl_mem_read = 0; s_ctrl_reg_write = 0;

        // Mid-cycle reset drops ex_valid immediately and clears the register file
        if_valid = 1; if_instr = mk(5'd5, 5'd7, 16'h0000);
        tick();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(ex_valid), 32'd0);
        check("async_rst_rs_data", ex_rs_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rf_cleared_r5", ex_rs_data, 32'h0);
        check("rf_cleared_r7", ex_rt_data, 32'h0);
        if_valid = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised decode stage for the MUSA core.
- Contains the integer register file (async reset, write-back port with same-cycle bypass), immediate extension, destination-register selection and a registered ID/EX pipeline boundary.
- Pipeline boundary uses a valid/ready handshake, flush, load-use hazard stall and a saturating stall counter.
- Sits between the IF stage (instruction in) and the EX stage (operands out); control signals come from the control unit combinationally.

Parameters:
DATA_W, 32, register/operand width; must be >= IMM_W
NUM_REGS, 32, implemented registers (2..32); index 0 hardwired to zero
IMM_W, 16, immediate field width taken from instr[IMM_W-1:0]
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  if_instr valid
if_ready  out  1  stage accepts if_instr this cycle
if_instr  in  32  instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11]
ctrl_reg_dst  in  1  1: dest=rd, 0: dest=rt
ctrl_zext  in  1  1: zero-extend immediate, 0: sign-extend
ctrl_mem_read  in  1  instruction is a load
ctrl_reg_write  in  1  instruction writes a register
flush  in  1  kill instruction in ID and ID/EX
wb_en  in  1  write-back enable
wb_addr  in  5  write-back register index
wb_data  in  DATA_W  write-back data
ex_valid  out  1  ID/EX holds a valid instruction
ex_ready  in  1  EX accepts ID/EX contents
ex_rs_data  out  DATA_W  rs operand
ex_rt_data  out  DATA_W  rt operand
ex_imm  out  DATA_W  extended immediate
ex_rs  out  5  rs index
ex_rt  out  5  rt index
ex_dest  out  5  destination index
ex_mem_read  out  1  registered ctrl_mem_read
ex_reg_write  out  1  registered ctrl_reg_write
ex_jump  out  26  instr[25:0]
stall_count  out  CNT_W  cycles lost to load-use stalls

Behaviour:
- Reset (async, immediate):
  - All registers in the register file = 0.
  - All ex_* outputs = 0, including ex_valid.
  - stall_count = 0.
  - if_ready is combinational; it is 0 while rst is high.
- Register file:
  - Two combinational read ports (rs, rt). Index 0 or index >= NUM_REGS reads 0.
  - Write occurs on the clk edge when wb_en=1, wb_addr != 0 and wb_addr < NUM_REGS; otherwise the write is ignored.
  - Bypass: if a read index equals wb_addr and that write is valid, the read returns wb_data in the same cycle.
- Immediate: imm = instr[IMM_W-1:0], sign- or zero-extended to DATA_W per ctrl_zext.
- Destination: dest = ctrl_reg_dst ? rd : rt.
- Load-use hazard (combinational):
  - hazard = ex_valid & ex_mem_read & ex_dest != 0 & (ex_dest == rs | ex_dest == rt).
  - The comparison is conservative: rt is always compared.
- Handshake:
  - can_load = ~ex_valid | ex_ready.
  - if_ready = can_load & ~hazard & ~flush & ~rst.
  - An instruction transfers when if_valid & if_ready.
- ID/EX update on each clk edge, in priority order:
  1. flush=1 -> ex_valid <= 0, ex_mem_read <= 0, ex_reg_write <= 0; other fields don't-care.
  2. else if can_load & hazard -> insert bubble: ex_valid <= 0, ex_mem_read <= 0, ex_reg_write <= 0; stall_count increments.
  3. else if can_load -> load all fields from decode; ex_valid <= if_valid.
  4. else (EX back-pressure) -> hold all ex_* unchanged.
- Latency: 1 cycle from accepted instruction to ex_valid. A load-use dependency costs exactly 1 bubble; after the bubble the load has left ID/EX, so the hazard clears.
- stall_count increments only on bubble insertion; it saturates at all-ones (no wrap).
- Back-pressure with a pending hazard does not count as a stall and does not insert a bubble.
- Simultaneous WB write and ID read of the same register: the bypassed value is captured into ID/EX.
- Reset mid-operation: in-flight ID/EX contents are lost; ex_valid drops immediately.

Test Plan:
1. Reset, then write wb_addr=5, wb_data=0xDEADBEEF; one cycle later decode rs=5 -> ex_rs_data=0xDEADBEEF one cycle after acceptance. Write to reg 0 -> reads stay 0.
2. Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0x12345678 while ID decodes rt=7 -> ex_rt_data=0x12345678 next cycle.
3. Immediate extension: instr[15:0]=0x8001 with ctrl_zext=0 -> ex_imm=0xFFFF8001; with ctrl_zext=1 -> ex_imm=0x00008001.
4. Load-use: a load with dest=3 in ID/EX, followed by an instruction with rs=3 -> if_ready=0 for 1 cycle, ex_valid=0 bubble, stall_count=1; the dependent instruction is accepted the next cycle. Repeat with ex_dest=0 -> no stall.
5. Back-pressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* held stable, if_ready=0, stall_count unchanged. Flush during hold -> ex_valid=0 next edge.
6. Parameters DATA_W=16, NUM_REGS=8: write wb_addr=9 is ignored and reads of 9 return 0; imm 0x8000 -> ex_imm=0x8000. Counter saturation with CNT_W=2: 5 stalls -> stall_count=3.
